counter_sequencer: RTL and testbench

- Control block that sequences the board-level up-counter (4-bit load/count datapath driving the BCD/7-seg display path).
- Turns raw active-low push buttons and switch settings into clean one-cycle load and count-enable pulses for the counter.
- Paces counting from CLOCK_50 with a programmable tick divider and stops at a switch-selected terminal value.
- Sits between the top-level KEY/SW pins and the counter's load/enable/data inputs, and takes the counter output back as feedback.

---
 rtl/counter_sequencer_if.sv | 28 ++
 rtl/counter_sequencer.sv | 165 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Board-side bundle between the KEY/SW pins, the up-counter and the sequencer.
// master = board/counter side, slave = sequencer.
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             key_load_n;
   logic             key_run_n;
   logic             key_step_n;
   logic [WIDTH-1:0] sw_data;
   logic [WIDTH-1:0] sw_stop;
   logic             stop_en;
   logic [WIDTH-1:0] cnt_q;
   logic             cnt_load;
   logic [WIDTH-1:0] cnt_d;
   logic             cnt_en;
   logic [2:0]       state;
   logic             done;

   modport master (
      output key_load_n, key_run_n, key_step_n, sw_data, sw_stop, stop_en, cnt_q,
      input  cnt_load, cnt_d, cnt_en, state, done
   );

   modport slave (
      input  key_load_n, key_run_n, key_step_n, sw_data, sw_stop, stop_en, cnt_q,
      output cnt_load, cnt_d, cnt_en, state, done
   );
endinterface

// File: rtl/counter_sequencer.sv
// Sequencer for the board up-counter: debounced keys drive a Moore FSM that
// issues load / count-enable strobes, paced by a tick divider, with terminal stop.
module cs_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);
   localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]    sync_q, sync_d;
   logic          db_q, db_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic          press_q, press_d;

   // Level flips only after DB_CYCLES consecutive disagreeing samples.
   always_comb begin
      sync_d   = {sync_q[0], key_n};
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync_q[1] != db_q) begin
         if (db_cnt_q == CW'(DB_CYCLES - 1)) db_d = sync_q[1];
         else db_cnt_d = db_cnt_q + 1'b1;
      end
      press_d = db_q & ~db_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= 2'b11;
         db_q     <= 1'b1;
         db_cnt_q <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;
endmodule

module counter_sequencer #(
   parameter int WIDTH     = 4,
   parameter int DIV       = 50000000,
   parameter int DB_CYCLES = 500000
) (
   input logic               clk,
   input logic               rst,
   counter_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_STEP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam int DW = $clog2(DIV);

   logic [2:0] key_n, press;
   logic       load_p, run_p, step_p;

   assign key_n = {bus.key_step_n, bus.key_run_n, bus.key_load_n};

   cs_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n),
      .press (press)
   );

   // Coincident presses resolve load > run > step; losers are dropped.
   assign load_p = press[0];
   assign run_p  = press[1] & ~press[0];
   assign step_p = press[2] & ~press[1] & ~press[0];

   logic [2:0]       state_q, state_d;
   logic             cnt_load_q, cnt_load_d;
   logic             cnt_en_q, cnt_en_d;
   logic [WIDTH-1:0] cnt_d_q, cnt_d_d;
   logic [WIDTH-1:0] stop_val_q, stop_val_d;
   logic [DW-1:0]    div_q, div_d;
   logic             armed_q, armed_d;
   logic             done_q, done_d;

   always_comb begin
      state_d    = state_q;
      cnt_load_d = 1'b0;
      cnt_en_d   = 1'b0;
      cnt_d_d    = cnt_d_q;
      stop_val_d = stop_val_q;
      div_d      = div_q;
      armed_d    = armed_q;
      if (load_p) begin
         state_d    = S_LOAD;
         cnt_load_d = 1'b1;
         cnt_d_d    = bus.sw_data;
         stop_val_d = bus.sw_stop;
      end else begin
         case (state_q)
            S_IDLE, S_PAUSE: begin
               if (run_p) begin
                  state_d = S_RUN;
                  div_d   = '0;
                  armed_d = 1'b0;
               end else if (step_p) begin
                  state_d  = S_STEP;
                  cnt_en_d = 1'b1;
                  armed_d  = 1'b1;
               end
            end
            S_LOAD, S_STEP: state_d = S_PAUSE;
            S_RUN: begin
               // Requiring cnt_en_q=0 makes the compare see post-increment feedback.
               if (run_p) begin
                  state_d = S_PAUSE;
               end else if (bus.stop_en && armed_q && !cnt_en_q && bus.cnt_q == stop_val_q) begin
                  state_d = S_DONE;
               end else if (div_q == DW'(DIV - 1)) begin
                  div_d    = '0;
                  cnt_en_d = 1'b1;
                  armed_d  = 1'b1;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_load_q <= 1'b0;
         cnt_en_q   <= 1'b0;
         cnt_d_q    <= '0;
         stop_val_q <= '0;
         div_q      <= '0;
         armed_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_load_q <= cnt_load_d;
         cnt_en_q   <= cnt_en_d;
         cnt_d_q    <= cnt_d_d;
         stop_val_q <= stop_val_d;
         div_q      <= div_d;
         armed_q    <= armed_d;
         done_q     <= done_d;
      end
   end

   assign bus.cnt_load = cnt_load_q;
   assign bus.cnt_en   = cnt_en_q;
   assign bus.cnt_d    = cnt_d_q;
   assign bus.state    = state_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed-plus-random bench for counter_sequencer with a behavioural board counter
// and arithmetic expectations for pulse counts, pacing and terminal stop.
module tb_counter_sequencer;
   localparam int W   = 4;
   localparam int DIV = 4;
   localparam int DB  = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_load = 0;
   int   en_q[$];
   logic [W-1:0] cnt_m;

   counter_sequencer_if #(.WIDTH(W)) bus ();

   counter_sequencer #(.WIDTH(W), .DIV(DIV), .DB_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Board up-counter fed by the sequencer strobes.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt_m <= '0;
      else if (bus.cnt_load) cnt_m <= bus.cnt_d;
      else if (bus.cnt_en) cnt_m <= cnt_m + 1'b1;
   end
   assign bus.cnt_q = cnt_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cnt_en) en_q.push_back(cyc);
         if (bus.cnt_load) n_load++;
         check("load_en_excl", {31'd0, bus.cnt_load & bus.cnt_en}, 32'd0);
         check("done_iff_state5", {31'd0, bus.done}, {31'd0, bus.state == 3'd5});
      end
   end

   function automatic int count_en(input int lo, input int hi);
      int n = 0;
      foreach (en_q[i]) if (en_q[i] >= lo && en_q[i] <= hi) n++;
      return n;
   endfunction

   task automatic wait_state(input logic [2:0] exp, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.state == exp) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
   endtask

   task automatic do_load(input logic [W-1:0] d, input logic [W-1:0] s, input string tag);
      int t, l0;
      l0 = n_load;
      bus.sw_data = d;
      bus.sw_stop = s;
      bus.key_load_n = 1'b0;
      wait_state(3'd1, 30, t);
      check({tag, "_state1"}, {29'd0, bus.state}, 32'd1);
      check({tag, "_strobe"}, {31'd0, bus.cnt_load}, 32'd1);
      check({tag, "_cnt_d"}, {28'd0, bus.cnt_d}, {28'd0, d});
      @(negedge clk);
      check({tag, "_state3"}, {29'd0, bus.state}, 32'd3);
      bus.key_load_n = 1'b1;
      settle();
      check({tag, "_one_pulse"}, n_load - l0, 32'd1);
      check({tag, "_counter"}, {28'd0, cnt_m}, {28'd0, d});
   endtask

   initial begin
      int t_run, t_pause, t_done, t, e0, first, bad, k;
      logic [W-1:0] d, s;
      rst = 1'b1;
      bus.key_load_n = 1'b1; bus.key_run_n = 1'b1; bus.key_step_n = 1'b1;
      bus.sw_data = '0; bus.sw_stop = '0; bus.stop_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", {29'd0, bus.state}, 32'd0);
      check("rst_load", {31'd0, bus.cnt_load}, 32'd0);
      check("rst_en", {31'd0, bus.cnt_en}, 32'd0);
      check("rst_cnt_d", {28'd0, bus.cnt_d}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // short glitch is filtered
      e0 = n_load;
      bus.key_load_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.key_load_n = 1'b1;
      repeat (12) @(negedge clk);
      check("glitch_no_load", n_load - e0, 32'd0);
      check("glitch_state", {29'd0, bus.state}, 32'd0);

      do_load(4'h7, 4'h0, "load7");

      // RUN pacing then pause
      bus.key_run_n = 1'b0;
      wait_state(3'd2, 30, t_run);
      check("run_enter", {29'd0, bus.state}, 32'd2);
      bus.key_run_n = 1'b1;
      repeat (16) @(negedge clk);
      bus.key_run_n = 1'b0;
      wait_state(3'd3, 30, t_pause);
      check("pause_enter", {29'd0, bus.state}, 32'd3);
      bus.key_run_n = 1'b1;
      check("run_pulses", count_en(t_run, t_pause), (t_pause - 1 - t_run) / DIV);
      first = -1; bad = 0;
      foreach (en_q[i]) if (en_q[i] >= t_run && en_q[i] < t_pause) begin
         if (first < 0) first = en_q[i];
         else if (i > 0 && en_q[i] - en_q[i-1] != DIV) bad++;
      end
      check("run_first_latency", first - t_run, DIV);
      check("run_spacing", bad, 32'd0);
      e0 = en_q.size();
      repeat (14) @(negedge clk);
      check("pause_no_en", en_q.size() - e0, 32'd0);

      // terminal count, spec case then random
      bus.stop_en = 1'b1;
      for (int it = 0; it < 2; it++) begin
         d = (it == 0) ? 4'd2 : 4'($urandom_range(0, 15));
         s = (it == 0) ? 4'd5 : 4'($urandom_range(0, 15));
         k = ((int'(s) - int'(d) - 1) & 15) + 1;
         do_load(d, s, "tc_load");
         bus.key_run_n = 1'b0;
         wait_state(3'd2, 30, t_run);
         bus.key_run_n = 1'b1;
         wait_state(3'd5, k * DIV + 40, t_done);
         check("tc_done_state", {29'd0, bus.state}, 32'd5);
         check("tc_done_flag", {31'd0, bus.done}, 32'd1);
         check("tc_counter", {28'd0, cnt_m}, {28'd0, s});
         check("tc_pulses", count_en(t_run, t_done), k);
         settle();
         e0 = en_q.size();
         bus.key_run_n = 1'b0; settle(); bus.key_run_n = 1'b1; settle();
         check("done_run_ignored", {29'd0, bus.state}, 32'd5);
         bus.key_step_n = 1'b0; settle(); bus.key_step_n = 1'b1; settle();
         check("done_step_ignored", {29'd0, bus.state}, 32'd5);
         check("done_no_en", en_q.size() - e0, 32'd0);
      end

      // load and run pressed together
      d = 4'($urandom_range(0, 15));
      e0 = en_q.size();
      bus.sw_data = d;
      bus.key_load_n = 1'b0; bus.key_run_n = 1'b0;
      wait_state(3'd1, 30, t);
      check("both_load", {29'd0, bus.state}, 32'd1);
      check("both_cnt_d", {28'd0, bus.cnt_d}, {28'd0, d});
      bus.key_load_n = 1'b1; bus.key_run_n = 1'b1;
      settle();
      check("both_end_pause", {29'd0, bus.state}, 32'd3);
      check("both_no_en", en_q.size() - e0, 32'd0);

      // single step from PAUSE
      bus.key_step_n = 1'b0;
      wait_state(3'd4, 30, t);
      check("step_state", {29'd0, bus.state}, 32'd4);
      check("step_en", {31'd0, bus.cnt_en}, 32'd1);
      @(negedge clk);
      check("step_back", {29'd0, bus.state}, 32'd3);
      bus.key_step_n = 1'b1;
      settle();
      check("step_one_pulse", count_en(t, cyc), 32'd1);
      check("step_counter", {28'd0, cnt_m}, {28'd0, d + 4'd1});

      // random loads
      for (int it = 0; it < 4; it++)
         do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd_load");

      // reset during a live cnt_en pulse
      bus.stop_en = 1'b0;
      bus.key_run_n = 1'b0;
      wait_state(3'd2, 30, t);
      bus.key_run_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.cnt_en) break;
      end
      check("pre_rst_en", {31'd0, bus.cnt_en}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_en", {31'd0, bus.cnt_en}, 32'd0);
      check("mid_rst_load", {31'd0, bus.cnt_load}, 32'd0);
      check("mid_rst_state", {29'd0, bus.state}, 32'd0);
      check("mid_rst_cnt_d", {28'd0, bus.cnt_d}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_state", {29'd0, bus.state}, 32'd0);
      do_load(4'($urandom_range(0, 15)), 4'h0, "post_rst_load");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
